// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Single-outstanding instruction fetch stage with a held output
//                register, PC redirect handling and a sticky misalign trap.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        misalign_err,
    output logic [31:0] retired
);

    localparam logic [1:0]  c_ST_FETCH  = 2'd0;
    localparam logic [1:0]  c_ST_WAIT   = 2'd1;
    localparam logic [1:0]  c_ST_HOLD   = 2'd2;
    localparam logic [1:0]  c_ST_ERR    = 2'd3;
    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0013;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_run;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_misalign;
    logic [31:0] r_retired;

    logic        w_accept;
    logic        w_bad_target;
    logic [31:0] w_pc_plus4;
    logic        w_imem_req;
    logic        w_instr_valid;

    assign w_accept     = (r_state == c_ST_HOLD) && !stall;
    assign w_bad_target = PCSrc && (PCTarget[1:0] != 2'b00);
    assign w_pc_plus4   = r_pc + 32'd4;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_FETCH: begin
                if (r_run && imem_gnt) begin
                    w_next_state = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (imem_rvalid) begin
                    w_next_state = c_ST_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (!stall) begin
                    w_next_state = w_bad_target ? c_ST_ERR : c_ST_FETCH;
                end
            end
            c_ST_ERR: begin
                w_next_state = c_ST_ERR;
            end
            default: begin
                w_next_state = c_ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_imem_req    = 1'b0;
        w_instr_valid = 1'b0;
        case (r_state)
            c_ST_FETCH: w_imem_req    = r_run;
            c_ST_HOLD:  w_instr_valid = 1'b1;
            default: begin
                w_imem_req    = 1'b0;
                w_instr_valid = 1'b0;
            end
        endcase
    end

    // Holds the request low while in reset and lets it rise on the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= c_NOP_INSTR;
        end else if ((r_state == c_ST_WAIT) && imem_rvalid) begin
            r_instr <= imem_rdata;
        end
    end

    // A misaligned redirect still retires the instruction but leaves PC untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_retired  <= 32'd0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_retired <= r_retired + 32'd1;
            if (w_bad_target) begin
                r_misalign <= 1'b1;
            end else if (PCSrc) begin
                r_pc <= PCTarget;
            end else begin
                r_pc <= w_pc_plus4;
            end
        end
    end

    assign imem_req     = w_imem_req;
    assign imem_addr    = r_pc;
    assign Instr        = r_instr;
    assign instr_valid  = w_instr_valid;
    assign PC           = r_pc;
    assign PCPlus4      = w_pc_plus4;
    assign misalign_err = r_misalign;
    assign retired      = r_retired;

endmodule
`default_nettype wire
